// File: rtl/dma_pkg.sv
// Shared DMA resolver types: channel count, channel index type and the
// one-hot resolver state encoding.
package dma_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

  localparam int unsigned ST_IDLE    = 0;
  localparam int unsigned ST_GRANT   = 1;
  localparam int unsigned ST_SERVICE = 2;
  localparam int unsigned ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 3'b001,
    S_GRANT   = 3'b010,
    S_SERVICE = 3'b100
  } res_state_t;

endpackage

// File: rtl/rot_prio_enc.sv
// Fixed / rotating priority encoder: picks the first requesting channel,
// searching from channel 0 (fixed) or from lowPri+1 (rotating).
module rot_prio_enc
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           lowPri,
  input  logic              rotatingPri,
  output logic              valid,
  output ch_idx_t           idx
);

  ch_idx_t start;
  ch_idx_t cand;

  always_comb begin
    start = rotatingPri ? ch_idx_t'(lowPri + 2'd1) : '0;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cand = start + CH_W'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/priority_resolver.sv
// DMA channel priority resolver: qualifies requests, latches a winner,
// tracks grant/service and produces DACK and terminal-count pulses.
module priority_resolver #(
  parameter int unsigned NUM_CH = dma_pkg::NUM_CH
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              rotatingPri,
  input  logic              ctrlDisable,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swReq,
  input  logic [NUM_CH-1:0] autoInit,
  input  logic              HLDA,
  input  logic              cycleStart,
  input  logic              cycleDone,
  input  logic              tcReached,
  output logic              reqPending,
  output logic [1:0]        grantCh,
  output logic [NUM_CH-1:0] DACK,
  output logic [NUM_CH-1:0] setMask,
  output logic [NUM_CH-1:0] clrSwReq
);
  import dma_pkg::*;

  logic [NUM_CH-1:0] dreq_q;
  logic [NUM_CH-1:0] eff_req;
  logic              enc_valid;
  ch_idx_t           enc_idx;

  res_state_t        state_q, state_d;
  ch_idx_t           grant_q, grant_d;
  ch_idx_t           low_pri_q, low_pri_d;
  logic              pend_q, pend_d;
  logic [NUM_CH-1:0] dack_q, dack_d;
  logic [NUM_CH-1:0] set_mask_q, set_mask_d;
  logic [NUM_CH-1:0] clr_sw_q, clr_sw_d;

  // Raw DREQ sampled once; no reset needed, it only feeds qualification.
  always_ff @(posedge CLK) begin
    dreq_q <= DREQ;
  end

  assign eff_req = ctrlDisable ? '0
                 : (((dreq_q ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | swReq);

  rot_prio_enc u_enc (
    .req         (eff_req),
    .lowPri      (low_pri_q),
    .rotatingPri (rotatingPri),
    .valid       (enc_valid),
    .idx         (enc_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    low_pri_d  = low_pri_q;
    pend_d     = pend_q;
    dack_d     = dack_q;
    set_mask_d = '0;
    clr_sw_d   = '0;
    if (state_q[ST_IDLE]) begin
      dack_d = '0;
      if (enc_valid) begin
        state_d = S_GRANT;
        grant_d = enc_idx;
        pend_d  = 1'b1;
      end
    end else if (state_q[ST_GRANT]) begin
      if (!eff_req[grant_q]) begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end else if (cycleStart && HLDA) begin
        state_d = S_SERVICE;
        dack_d  = NUM_CH'(1) << grant_q;
      end
    end else if (state_q[ST_SERVICE]) begin
      // Losing HLDA wins over a coincident cycleDone: abort, no TC side effects.
      if (!HLDA) begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        dack_d  = '0;
      end else if (cycleDone) begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        dack_d  = '0;
        if (rotatingPri) low_pri_d = grant_q;
        if (tcReached) begin
          clr_sw_d[grant_q]   = 1'b1;
          set_mask_d[grant_q] = ~autoInit[grant_q];
        end
      end
    end else begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      dack_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      low_pri_q  <= 2'd3;
      pend_q     <= 1'b0;
      dack_q     <= '0;
      set_mask_q <= '0;
      clr_sw_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      low_pri_q  <= low_pri_d;
      pend_q     <= pend_d;
      dack_q     <= dack_d;
      set_mask_q <= set_mask_d;
      clr_sw_q   <= clr_sw_d;
    end
  end

  assign reqPending = pend_q;
  assign grantCh    = grant_q;
  assign DACK       = dack_q ^ {NUM_CH{~dackActiveHigh}};
  assign setMask    = set_mask_q;
  assign clrSwReq   = clr_sw_q;

endmodule

// File: tb/tb_priority_resolver.sv
// Directed bench for priority_resolver: behavioural model checked every
// cycle plus hand-computed literal expectations.
module tb_priority_resolver;

  logic       CLK = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] DREQ = 4'b0;
  logic       dreqActiveLow = 1'b0;
  logic       dackActiveHigh = 1'b0;
  logic       rotatingPri = 1'b0;
  logic       ctrlDisable = 1'b0;
  logic [3:0] maskReg = 4'b0;
  logic [3:0] swReq = 4'b0;
  logic [3:0] autoInit = 4'b0;
  logic       HLDA = 1'b0;
  logic       cycleStart = 1'b0;
  logic       cycleDone = 1'b0;
  logic       tcReached = 1'b0;
  logic       reqPending;
  logic [1:0] grantCh;
  logic [3:0] DACK;
  logic [3:0] setMask;
  logic [3:0] clrSwReq;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  priority_resolver #(.NUM_CH(4)) dut (
    .CLK(CLK), .Reset(Reset), .DREQ(DREQ), .dreqActiveLow(dreqActiveLow),
    .dackActiveHigh(dackActiveHigh), .rotatingPri(rotatingPri),
    .ctrlDisable(ctrlDisable), .maskReg(maskReg), .swReq(swReq),
    .autoInit(autoInit), .HLDA(HLDA), .cycleStart(cycleStart),
    .cycleDone(cycleDone), .tcReached(tcReached), .reqPending(reqPending),
    .grantCh(grantCh), .DACK(DACK), .setMask(setMask), .clrSwReq(clrSwReq)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Search order: from 0 in fixed mode, from low+1 (mod 4) in rotating mode.
  function automatic int pick(input logic [3:0] r, input int low, input bit rot);
    int s;
    s = rot ? (low + 1) % 4 : 0;
    for (int k = 0; k < 4; k++)
      if (r[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  // Model: phase 0=idle, 1=winner latched, 2=transfer in progress.
  int         m_phase, m_grant, m_low;
  logic       m_pend;
  logic [3:0] m_dreq, m_eff, m_ack, m_setm, m_clr;

  always @(posedge CLK) begin
    m_eff  = ctrlDisable ? 4'b0 : (((m_dreq ^ {4{dreqActiveLow}}) & ~maskReg) | swReq);
    m_setm = 4'b0;
    m_clr  = 4'b0;
    if (!Reset) begin
      m_phase = 0; m_grant = 0; m_low = 3; m_pend = 1'b0; m_ack = 4'b0;
    end else if (m_phase == 0) begin
      if (m_eff != 4'b0) begin
        m_phase = 1; m_grant = pick(m_eff, m_low, rotatingPri); m_pend = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (!m_eff[m_grant]) begin
        m_phase = 0; m_pend = 1'b0;
      end else if (cycleStart && HLDA) begin
        m_phase = 2; m_ack = 4'b0001 << m_grant;
      end
    end else begin
      if (!HLDA) begin
        m_phase = 0; m_pend = 1'b0; m_ack = 4'b0;
      end else if (cycleDone) begin
        m_phase = 0; m_pend = 1'b0; m_ack = 4'b0;
        if (rotatingPri) m_low = m_grant;
        if (tcReached) begin
          m_clr[m_grant] = 1'b1;
          if (!autoInit[m_grant]) m_setm[m_grant] = 1'b1;
        end
      end
    end
    m_dreq = DREQ;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cyc_pending", {3'b0, reqPending}, {3'b0, m_pend});
      chk("cyc_grant", {2'b0, grantCh}, 4'(m_grant));
      chk("cyc_dack", DACK, m_ack ^ {4{~dackActiveHigh}});
      chk("cyc_setmask", setMask, m_setm);
      chk("cyc_clrswreq", clrSwReq, m_clr);
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    tick(1);
    chk_en = 1'b1;
    tick(1);
    chk("rst_dack_low", DACK, 4'b1111);
    chk("rst_pending", {3'b0, reqPending}, 4'b0);
    chk("rst_grant", {2'b0, grantCh}, 4'b0);
    dackActiveHigh = 1'b1;
    #1 chk("rst_dack_high", DACK, 4'b0000);
    Reset = 1'b1; HLDA = 1'b1;

    // Fixed mode, two requesters: ch1 wins two edges after DREQ.
    DREQ = 4'b1010;
    tick(1); chk("fix_pend_early", {3'b0, reqPending}, 4'b0);
    tick(1); chk("fix_grant", {2'b0, grantCh}, 4'd1);
    chk("fix_pend", {3'b0, reqPending}, 4'b1);
    cycleStart = 1'b1;
    tick(1); chk("fix_dack", DACK, 4'b0010);
    cycleStart = 1'b0; cycleDone = 1'b1; DREQ = 4'b0;
    tick(1); chk("fix_done_dack", DACK, 4'b0000);
    chk("fix_done_pend", {3'b0, reqPending}, 4'b0);
    cycleDone = 1'b0; tick(1);

    // Rotating: serve ch2, then lowPri=2 gives search order 3,0,1.
    rotatingPri = 1'b1; DREQ = 4'b0100;
    tick(2); chk("rot_grant2", {2'b0, grantCh}, 4'd2);
    cycleStart = 1'b1; tick(1); cycleStart = 1'b0;
    cycleDone = 1'b1; DREQ = 4'b0101; tick(1); cycleDone = 1'b0;
    tick(1); chk("rot_grant0", {2'b0, grantCh}, 4'd0);
    DREQ = 4'b0; tick(2); chk("rot_drop", {3'b0, reqPending}, 4'b0);
    DREQ = 4'b1101; tick(2); chk("rot_grant3", {2'b0, grantCh}, 4'd3);
    DREQ = 4'b0; tick(2);

    // Active-low DREQ switched under ctrlDisable.
    rotatingPri = 1'b0; ctrlDisable = 1'b1; dreqActiveLow = 1'b1; DREQ = 4'b1011;
    tick(2); chk("dis_pend", {3'b0, reqPending}, 4'b0);
    ctrlDisable = 1'b0; tick(1); chk("alow_grant", {2'b0, grantCh}, 4'd2);
    DREQ = 4'b1111; tick(2);
    ctrlDisable = 1'b1; dreqActiveLow = 1'b0; DREQ = 4'b0; tick(2);
    ctrlDisable = 1'b0;

    // Mask blocks hardware DREQ; software request bypasses it.
    maskReg = 4'b0001; DREQ = 4'b0001;
    tick(3); chk("mask_pend", {3'b0, reqPending}, 4'b0);
    swReq = 4'b0001; tick(1);
    chk("sw_grant", {2'b0, grantCh}, 4'd0);
    chk("sw_pend", {3'b0, reqPending}, 4'b1);
    swReq = 4'b0; maskReg = 4'b0; DREQ = 4'b0;
    tick(3); chk("sw_release", {3'b0, reqPending}, 4'b0);

    // Terminal count on ch1 without and with autoinit.
    for (int a = 0; a < 2; a++) begin
      autoInit = (a == 0) ? 4'b0000 : 4'b0010;
      DREQ = 4'b0010; tick(2);
      cycleStart = 1'b1; tick(1); cycleStart = 1'b0;
      cycleDone = 1'b1; tcReached = 1'b1; DREQ = 4'b0; tick(1);
      chk("tc_setmask", setMask, (a == 0) ? 4'b0010 : 4'b0000);
      chk("tc_clrswreq", clrSwReq, 4'b0010);
      cycleDone = 1'b0; tcReached = 1'b0; tick(1);
      chk("tc_setmask_end", setMask, 4'b0000);
      chk("tc_clrswreq_end", clrSwReq, 4'b0000);
    end
    autoInit = 4'b0;

    // HLDA lost in service: abort, lowPri stays 2.
    rotatingPri = 1'b1; DREQ = 4'b0010; tick(2);
    cycleStart = 1'b1; tick(1); cycleStart = 1'b0;
    chk("abort_dack_on", DACK, 4'b0010);
    HLDA = 1'b0; DREQ = 4'b0; tick(1);
    chk("abort_dack", DACK, 4'b0000);
    chk("abort_pend", {3'b0, reqPending}, 4'b0);
    chk("abort_setmask", setMask, 4'b0000);
    HLDA = 1'b1; DREQ = 4'b1111; tick(2);
    chk("abort_lowpri", {2'b0, grantCh}, 4'd3);

    // cycleDone together with HLDA low is an abort.
    cycleStart = 1'b1; tick(1); cycleStart = 1'b0;
    HLDA = 1'b0; cycleDone = 1'b1; tcReached = 1'b1; DREQ = 4'b0; tick(1);
    chk("abort2_clr", clrSwReq, 4'b0000);
    chk("abort2_dack", DACK, 4'b0000);
    HLDA = 1'b1; cycleDone = 1'b0; tcReached = 1'b0; DREQ = 4'b1111; tick(2);
    chk("abort2_lowpri", {2'b0, grantCh}, 4'd3);

    // Reset mid-service with active-low DACK beats cycleDone/TC.
    dackActiveHigh = 1'b0;
    cycleStart = 1'b1; tick(1); cycleStart = 1'b0;
    chk("svc_dack_low", DACK, 4'b0111);
    Reset = 1'b0; cycleDone = 1'b1; tcReached = 1'b1; tick(1);
    chk("midrst_dack", DACK, 4'b1111);
    chk("midrst_pend", {3'b0, reqPending}, 4'b0);
    chk("midrst_setmask", setMask, 4'b0000);
    chk("midrst_clr", clrSwReq, 4'b0000);
    Reset = 1'b1; cycleDone = 1'b0; tcReached = 1'b0; tick(1);
    chk("post_rst_grant", {2'b0, grantCh}, 4'd0);
    chk("post_rst_pend", {3'b0, reqPending}, 4'b1);
    DREQ = 4'b0; tick(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
